// File: rtl/msk_frame_tx.sv
// MSK frame transmitter: serialises a data word MSB first, one bit per `divisor` clocks,
// and steers the DDS phase increment between PIR_H / PIR_L (carrier while idle).
module msk_frame_tx #(
  parameter int WORD_W   = 30,
  parameter int DIV_W    = 16,
  parameter int PIR_W    = 32,
  parameter int DIFF_ENC = 0,
  localparam int IDX_W   = (WORD_W > 1) ? $clog2(WORD_W) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PIR_W-1:0]  PIR_carrier,
  input  logic [PIR_W-1:0]  PIR_H,
  input  logic [PIR_W-1:0]  PIR_L,
  input  logic [DIV_W-1:0]  divisor,
  input  logic [WORD_W-1:0] data_in,
  input  logic              load,
  input  logic              continuous,
  output logic              ready,
  output logic [PIR_W-1:0]  PIR,
  output logic              tx_bit,
  output logic [IDX_W-1:0]  bit_index,
  output logic              bit_clk_tick,
  output logic              two_bit_clk_TP,
  output logic              reset_DDS,
  output logic              done
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   shreg_q, shreg_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [DIV_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                tx_q, tx_d;
  logic                tick_q, tick_d;
  logic                tp_q, tp_d;
  logic                rdds_q, rdds_d;
  logic                done_q, done_d;
  logic                ready_q, ready_d;
  logic [PIR_W-1:0]    pir_q, pir_d;

  logic                start;
  logic                adv;
  logic                last_bit;
  logic [DIV_W-1:0]    div_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      div_q   <= DIV_W'(1);
      cnt_q   <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b0;
      tick_q  <= 1'b0;
      tp_q    <= 1'b0;
      rdds_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
      pir_q   <= PIR_carrier;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      tick_q  <= tick_d;
      tp_q    <= tp_d;
      rdds_q  <= rdds_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      pir_q   <= pir_d;
    end
  end

  always_comb begin
    div_in   = (divisor == '0) ? DIV_W'(1) : divisor;
    last_bit = (idx_q == IDX_W'(WORD_W - 1));
    state_d  = state_q;
    shreg_d  = shreg_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    start    = 1'b0;
    adv      = 1'b0;
    rdds_d   = 1'b0;
    tp_d     = tp_q ^ tick_q;

    case (state_q)
      IDLE: begin
        if (load) start = 1'b1;
      end
      SEND: begin
        if (tick_q) begin
          if (last_bit) begin
            if (continuous) start   = 1'b1;
            else            state_d = IDLE;
          end else begin
            adv     = 1'b1;
            shreg_d = shreg_q << 1;
            idx_d   = idx_q + IDX_W'(1);
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      adv     = 1'b1;
      state_d = SEND;
      shreg_d = data_in;
      div_d   = div_in;
      cnt_d   = '0;
      idx_d   = '0;
      rdds_d  = 1'b1;
    end

    if (state_d == IDLE) begin
      shreg_d = '0;
      cnt_d   = '0;
      idx_d   = '0;
    end

    // tx_q is 0 in IDLE, so differential history restarts from 0 after idle
    // and carries over across a continuous reload.
    if (state_d != SEND)  tx_d = 1'b0;
    else if (adv)         tx_d = shreg_d[WORD_W-1] ^ ((DIFF_ENC != 0) && tx_q);
    else                  tx_d = tx_q;

    tick_d  = (state_d == SEND) && (cnt_d == div_d - DIV_W'(1));
    done_d  = tick_d && (idx_d == IDX_W'(WORD_W - 1));
    ready_d = (state_d == IDLE);
    pir_d   = (state_d == SEND) ? (tx_d ? PIR_H : PIR_L) : PIR_carrier;
  end

  assign ready          = ready_q;
  assign PIR            = pir_q;
  assign tx_bit         = tx_q;
  assign bit_index      = idx_q;
  assign bit_clk_tick   = tick_q;
  assign two_bit_clk_TP = tp_q;
  assign reset_DDS      = rdds_q;
  assign done           = done_q;

endmodule
